pipe_hazard_ctrl: RTL and testbench

Parametrised hazard, stall, flush and forwarding controller for the ARM pipeline, sitting between ID and the ID/EX stage register. It shadows the post-ID stages with an internal slot pipeline of destination/source tags, and generates the signals the stages need: freeze for IF and IF/ID, clear for IF/ID, bubble insertion into ID/EX, and EX operand-forwarding selects. It supports a runtime forwarding on/off mode and keeps saturating stall and flush counters.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, stall, flush and forwarding controller between ID and ID/EX.
// Shadows the post-ID stages with a slot pipeline of register tags.
module pipe_hazard_ctrl #(
  parameter  int unsigned STAGES = 3,
  parameter  int unsigned RA_W   = 4,
  parameter  int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W  = $clog2(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_src1,
  input  logic [RA_W-1:0]  id_src2,
  input  logic             id_src1_en,
  input  logic             id_src2_en,
  input  logic [RA_W-1:0]  id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             branch_taken,
  input  logic             fwd_en,
  output logic             freeze,
  output logic             id_flush,
  output logic             bubble,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wb_en;
    logic            mem_r_en;
    logic [RA_W-1:0] src1;
    logic            src1_en;
    logic [RA_W-1:0] src2;
    logic            src2_en;
  } slot_t;

  slot_t            slot_q [STAGES];
  slot_t            slot_d [STAGES];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hz;

  function automatic logic writes_reg(slot_t s, logic [RA_W-1:0] r, logic en);
    return en & s.valid & s.wb_en & (s.dest == r);
  endfunction

  // The WB slot is never checked: the register file is write-first.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hz = 1'b0;
    if (fwd_en) begin
      hz = slot_q[0].mem_r_en &
           (writes_reg(slot_q[0], id_src1, id_src1_en) |
            writes_reg(slot_q[0], id_src2, id_src2_en));
    end else begin
      for (int k = 0; k < STAGES - 1; k++) begin
        hz = hz | writes_reg(slot_q[k], id_src1, id_src1_en)
                | writes_reg(slot_q[k], id_src2, id_src2_en);
      end
    end
    hz = hz & id_valid;
  end

  assign freeze   = ~rst & ~branch_taken & hz;
  assign id_flush = ~rst & branch_taken;
  assign bubble   = ~rst & (branch_taken | hz);

  // Descending scan so the youngest usable producer is the last one written.
  always_comb begin
    logic usable;
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    usable    = 1'b0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      usable = slot_q[k].valid & slot_q[k].wb_en & (~slot_q[k].mem_r_en | (k >= 2));
      if (usable && slot_q[0].src1_en && slot_q[k].dest == slot_q[0].src1)
        fwd_sel_a = SEL_W'(k);
      if (usable && slot_q[0].src2_en && slot_q[k].dest == slot_q[0].src2)
        fwd_sel_b = SEL_W'(k);
    end
    if (rst || !fwd_en || !slot_q[0].valid) begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
    end
  end

  always_comb begin
    for (int k = 1; k < STAGES; k++) slot_d[k] = slot_q[k-1];
    slot_d[0] = '0;
    if (!bubble) begin
      slot_d[0] = '{valid: id_valid, dest: id_dest, wb_en: id_wb_en,
                    mem_r_en: id_mem_r_en, src1: id_src1, src1_en: id_src1_en,
                    src2: id_src2, src2_en: id_src2_en};
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (freeze && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (id_flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      // NOTE: the slot array is small flop state and must be cleared so no stale tag matches.
      for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) slot_q[k] <= slot_d[k];
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = rst ? '0 : stall_cnt_q;
  assign flush_cnt = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl against an in-flight
// instruction model (STAGES=3, RA_W=4, CNT_W=4 for reachable saturation).
module tb_pipe_hazard_ctrl;

  localparam int S     = 3;
  localparam int RA_W  = 4;
  localparam int CNT_W = 4;
  localparam int SEL_W = $clog2(S);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [RA_W-1:0]  id_src1, id_src2, id_dest;
  logic             id_src1_en, id_src2_en, id_wb_en, id_mem_r_en;
  logic             branch_taken, fwd_en;
  logic             freeze, id_flush, bubble;
  logic [SEL_W-1:0] fwd_sel_a, fwd_sel_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.STAGES(S), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_src1_en(id_src1_en), .id_src2_en(id_src2_en),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .fwd_en(fwd_en),
    .freeze(freeze), .id_flush(id_flush), .bubble(bubble),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instructions in flight after ID; index = number of cycles since leaving ID.
  typedef struct {
    bit v; bit wb; bit ld;
    int dest; int s1; bit e1; int s2; bit e2;
  } ins_t;

  ins_t inflight [S];
  int   m_stall, m_flush;
  bit   e_freeze, e_flush, e_bubble;
  int   e_sel_a, e_sel_b, e_stall, e_flush_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit writes(ins_t p, int r, bit en);
    return en && p.v && p.wb && p.dest == r;
  endfunction

  function automatic int pick(int r, bit en);
    for (int i = 1; i < S; i++)
      if (writes(inflight[i], r, en) && (!inflight[i].ld || i >= 2)) return i;
    return 0;
  endfunction

  task automatic compute_expected();
    bit hz;
    hz = 0;
    e_freeze = 0; e_flush = 0; e_bubble = 0; e_sel_a = 0; e_sel_b = 0;
    if (!rst) begin
      if (fwd_en)
        hz = inflight[0].ld && (writes(inflight[0], id_src1, id_src1_en) ||
                                writes(inflight[0], id_src2, id_src2_en));
      else
        for (int i = 0; i < S - 1; i++)
          if (writes(inflight[i], id_src1, id_src1_en) ||
              writes(inflight[i], id_src2, id_src2_en)) hz = 1;
      hz = hz && id_valid;
      if (branch_taken) begin
        e_flush = 1; e_bubble = 1;
      end else if (hz) begin
        e_freeze = 1; e_bubble = 1;
      end
      if (fwd_en && inflight[0].v) begin
        e_sel_a = pick(inflight[0].s1, inflight[0].e1);
        e_sel_b = pick(inflight[0].s2, inflight[0].e2);
      end
    end
    e_stall     = rst ? 0 : m_stall;
    e_flush_cnt = rst ? 0 : m_flush;
  endtask

  task automatic model_update();
    ins_t empty;
    empty = '{default: 0};
    compute_expected();
    if (rst) begin
      for (int i = 0; i < S; i++) inflight[i] = empty;
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (e_flush && m_flush < CMAX) m_flush++;
      if (e_freeze && m_stall < CMAX) m_stall++;
      for (int i = S - 1; i >= 1; i--) inflight[i] = inflight[i-1];
      if (e_bubble) inflight[0] = empty;
      else inflight[0] = '{v: id_valid, wb: id_wb_en, ld: id_mem_r_en, dest: id_dest,
                           s1: id_src1, e1: id_src1_en, s2: id_src2, e2: id_src2_en};
    end
  endtask

  task automatic settle_check();
    #1;
    compute_expected();
    check("freeze",    freeze,    e_freeze);
    check("id_flush",  id_flush,  e_flush);
    check("bubble",    bubble,    e_bubble);
    check("fwd_sel_a", fwd_sel_a, e_sel_a);
    check("fwd_sel_b", fwd_sel_b, e_sel_b);
    check("stall_cnt", stall_cnt, e_stall);
    check("flush_cnt", flush_cnt, e_flush_cnt);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic issue(input int dest, input bit wb, input bit ld,
                       input int s1, input bit e1, input int s2, input bit e2);
    id_valid = 1; id_dest = dest[RA_W-1:0]; id_wb_en = wb; id_mem_r_en = ld;
    id_src1 = s1[RA_W-1:0]; id_src1_en = e1; id_src2 = s2[RA_W-1:0]; id_src2_en = e2;
  endtask

  task automatic idle(input int n);
    id_valid = 0; branch_taken = 0;
    repeat (n) begin settle_check(); advance(); end
  endtask

  task automatic do_reset();
    rst = 1; id_valid = 0; branch_taken = 0;
    settle_check();
    advance();
    rst = 0;
  endtask

  initial begin
    rst = 1; fwd_en = 0; branch_taken = 0;
    issue(0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
    for (int i = 0; i < S; i++) inflight[i] = '{default: 0};
    m_stall = 0; m_flush = 0;
    @(negedge clk);

    // Reset forces every output low even with hazardous inputs and a branch.
    issue(4, 1, 1, 1, 1, 2, 1);
    branch_taken = 1;
    repeat (2) begin
      settle_check();
      check("rst_freeze", freeze, 0);
      check("rst_flush", id_flush, 0);
      check("rst_bubble", bubble, 0);
      advance();
    end
    rst = 0; branch_taken = 0;
    issue(0, 0, 0, 1, 1, 2, 1);
    settle_check();
    check("post_rst_stall_cnt", stall_cnt, 0);
    check("post_rst_flush_cnt", flush_cnt, 0);
    check("post_rst_no_match", freeze, 0);
    advance();
    idle(3);

    // No-forward RAW: producer directly ahead stalls S-1 cycles.
    do_reset();
    fwd_en = 0;
    issue(1, 1, 0, 0, 0, 0, 0); settle_check(); check("raw_prod_free", freeze, 0); advance();
    issue(5, 1, 0, 1, 1, 0, 0); settle_check();
    check("raw_freeze1", freeze, 1); check("raw_bubble1", bubble, 1); advance();
    settle_check(); check("raw_freeze2", freeze, 1); advance();
    settle_check(); check("raw_release", freeze, 0); check("raw_stall_cnt", stall_cnt, 2);
    advance();
    idle(3);

    // Forwarding RAW: R1 two ahead, R3 one ahead of the consumer.
    do_reset();
    fwd_en = 1;
    issue(1, 1, 0, 0, 0, 0, 0); settle_check(); advance();
    issue(3, 1, 0, 0, 0, 0, 0); settle_check(); advance();
    issue(4, 1, 0, 1, 1, 3, 1); settle_check(); check("fwd_no_freeze", freeze, 0); advance();
    id_valid = 0; settle_check();
    check("fwd_sel_a_R1", fwd_sel_a, 2); check("fwd_sel_b_R3", fwd_sel_b, 1);
    advance();
    idle(3);

    // Load-use: one stall, then forward from the WB slot.
    do_reset();
    fwd_en = 1;
    issue(2, 1, 1, 0, 0, 0, 0); settle_check(); advance();
    issue(6, 1, 0, 0, 0, 2, 1); settle_check(); check("lu_freeze", freeze, 1); advance();
    settle_check(); check("lu_release", freeze, 0); check("lu_sel_b_mem", fwd_sel_b, 0); advance();
    id_valid = 0; settle_check();
    check("lu_sel_b_wb", fwd_sel_b, 2); check("lu_stall_cnt", stall_cnt, 1);
    advance();
    idle(3);

    // Branch coinciding with a hazard: flush wins, slot 0 gets a bubble.
    do_reset();
    fwd_en = 0;
    issue(7, 1, 0, 0, 0, 0, 0); settle_check(); advance();
    issue(8, 1, 1, 7, 1, 0, 0); branch_taken = 1; settle_check();
    check("br_freeze", freeze, 0); check("br_id_flush", id_flush, 1); check("br_bubble", bubble, 1);
    advance();
    branch_taken = 0; fwd_en = 1;
    issue(9, 1, 0, 8, 1, 0, 0); settle_check();
    check("br_slot0_empty", freeze, 0);
    check("br_flush_cnt", flush_cnt, 1); check("br_stall_cnt", stall_cnt, 0);
    advance();
    idle(3);

    // Counter saturation, then reset clears both.
    do_reset();
    fwd_en = 0;
    repeat (10) begin
      issue(1, 1, 0, 0, 0, 0, 0); settle_check(); advance();
      issue(2, 1, 0, 1, 1, 0, 0); settle_check(); advance();
      settle_check(); advance();
    end
    id_valid = 0; settle_check(); check("sat_stall_cnt", stall_cnt, CMAX);
    branch_taken = 1;
    repeat (20) begin settle_check(); advance(); end
    branch_taken = 0; settle_check(); check("sat_flush_cnt", flush_cnt, CMAX);
    rst = 1; settle_check(); check("sat_rst_forced", stall_cnt, 0); advance();
    rst = 0; settle_check();
    check("sat_rst_stall", stall_cnt, 0); check("sat_rst_flush", flush_cnt, 0);
    advance();

    // Randomized traffic over a small register set so hazards are frequent.
    repeat (3000) begin
      rst          = ($urandom_range(49) == 0);
      branch_taken = ($urandom_range(7) == 0);
      if ($urandom_range(15) == 0) fwd_en = ~fwd_en;
      id_valid    = ($urandom_range(4) != 0);
      id_dest     = RA_W'($urandom_range(3));
      id_wb_en    = ($urandom_range(3) != 0);
      id_mem_r_en = ($urandom_range(2) == 0);
      id_src1     = RA_W'($urandom_range(3));
      id_src2     = RA_W'($urandom_range(3));
      id_src1_en  = ($urandom_range(3) != 0);
      id_src2_en  = ($urandom_range(3) != 0);
      settle_check();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
